// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: write-side initiator for the register file.
//
// Collects writeback requests from the memory-load and ALU sources into a small
// in-order circular queue and drains it through the register file write port at
// one write per clock. Also publishes a mask of registers with writes in flight.
//
// Ports:
//   clk        system clock, rising edge
//   nClear     asynchronous active-low reset
//   mem_*      memory-load writeback request (valid/addr/data) and mem_ready
//   alu_*      ALU writeback request (valid/addr/data) and alu_ready
//   Caddr, C   register file write address / data (zero when idle)
//   load       register file write enable
//   pend_mask  bit r set while any queued entry targets register r
//
// Optional feature: define WB_COALESCE_EN to merge an accepted request into the
// youngest queued entry when the addresses match and that entry is not the head.

module reg_wb_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 16
) (
    input  logic                 clk,
    input  logic                 nClear,
    input  logic                 mem_valid,
    input  logic [AW-1:0]        mem_addr,
    input  logic [DW-1:0]        mem_data,
    output logic                 mem_ready,
    input  logic                 alu_valid,
    input  logic [AW-1:0]        alu_addr,
    input  logic [DW-1:0]        alu_data,
    output logic                 alu_ready,
    output logic [AW-1:0]        Caddr,
    output logic [DW-1:0]        C,
    output logic                 load,
    output logic [(2**AW)-1:0]   pend_mask
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

`ifdef WB_COALESCE_EN
    localparam bit Coalesce = 1'b1;
`else
    localparam bit Coalesce = 1'b0;
`endif

    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [CW-1:0] free;
    logic          pop;
    logic          mem_push, alu_push;
    logic [CW-1:0] occ;      // occupancy incl. head and entries allocated so far this cycle
    logic [CW-1:0] ins;      // entries allocated this cycle
    logic [PW-1:0] yidx;     // index of the youngest entry

    // Ready depends only on the registered count; a same-cycle pop gives no credit.
    always_comb begin
        free      = DepthC - count_q;
        mem_ready = (free >= CW'(1));
        alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !mem_valid);
    end

    assign pop      = (count_q != '0);
    assign mem_push = mem_valid && mem_ready && (mem_addr != '0);
    assign alu_push = alu_valid && alu_ready && (alu_addr != '0);

    // Enqueue mem first, then ALU, so equal addresses leave the ALU value last.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        head_d = head_q;
        tail_d = tail_q;
        occ    = count_q;
        ins    = '0;
        yidx   = '0;

        if (pop) begin
            head_d = head_q + 1'b1;
        end

        if (mem_push) begin
            yidx = tail_d - 1'b1;
            // occ >= 2 guarantees the youngest entry is not the head.
            if (Coalesce && (occ >= CW'(2)) && (addr_d[yidx] == mem_addr)) begin
                data_d[yidx] = mem_data;
            end else begin
                addr_d[tail_d] = mem_addr;
                data_d[tail_d] = mem_data;
                tail_d         = tail_d + 1'b1;
                occ            = occ + 1'b1;
                ins            = ins + 1'b1;
            end
        end

        if (alu_push) begin
            yidx = tail_d - 1'b1;
            if (Coalesce && (occ >= CW'(2)) && (addr_d[yidx] == alu_addr)) begin
                data_d[yidx] = alu_data;
            end else begin
                addr_d[tail_d] = alu_addr;
                data_d[tail_d] = alu_data;
                tail_d         = tail_d + 1'b1;
                occ            = occ + 1'b1;
                ins            = ins + 1'b1;
            end
        end

        count_d = count_q + ins - CW'(pop);
    end

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Write port is driven straight from the head entry.
    always_comb begin
        load  = pop;
        Caddr = pop ? addr_q[head_q] : '0;
        C     = pop ? data_q[head_q] : '0;
    end

    always_comb begin
        pend_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_q) begin
                pend_mask[addr_q[PW'(head_q + PW'(k))]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
module tb_reg_wb_ctrl;

    localparam int DEPTH = 4;

`ifdef WB_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    logic        clk;
    logic        nClear;
    logic        mem_valid, alu_valid;
    logic [3:0]  mem_addr, alu_addr;
    logic [15:0] mem_data, alu_data;
    logic        mem_ready, alu_ready;
    logic [3:0]  Caddr;
    logic [15:0] C;
    logic        load;
    logic [15:0] pend_mask;

    reg_wb_ctrl #(.DEPTH(DEPTH), .AW(4), .DW(16)) dut (
        .clk       (clk),
        .nClear    (nClear),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .Caddr     (Caddr),
        .C         (C),
        .load      (load),
        .pend_mask (pend_mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: model_q is the set of queued writes, exp_q the writes still
    // expected on the port (scoreboard consumed by the monitor).
    ent_t model_q[$];
    ent_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   ycount;
    int   sz;
    bit   last_macc, last_aacc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_alu_ready(input int size, input logic mv);
        int f = DEPTH - size;
        return (f >= 2) || (f == 1 && !mv);
    endfunction

    function automatic void add(input logic [3:0] a, input logic [15:0] d);
        ent_t e;
        if (COAL && ycount >= 2 && model_q.size() > 0 && model_q[model_q.size()-1].a == a) begin
            e = model_q.pop_back();
            e.d = d;
            model_q.push_back(e);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_back();
                e.d = d;
                exp_q.push_back(e);
            end
        end else begin
            e.a = a;
            e.d = d;
            model_q.push_back(e);
            exp_q.push_back(e);
            ycount++;
        end
    endfunction

    // Model update on each active edge.
    initial begin
        forever begin
            @(posedge clk);
            if (nClear) begin
                sz        = model_q.size();
                last_macc = mem_valid && (sz < DEPTH);
                last_aacc = alu_valid && model_alu_ready(sz, mem_valid);
                ycount    = sz;
                if (sz > 0) void'(model_q.pop_front());
                if (last_macc && mem_addr != 4'd0) add(mem_addr, mem_data);
                if (last_aacc && alu_addr != 4'd0) add(alu_addr, alu_data);
            end else begin
                last_macc = 1'b0;
                last_aacc = 1'b0;
            end
        end
    end

    // Monitor: compares the write port, ready and pend_mask every cycle.
    initial begin
        ent_t        e;
        logic [15:0] m;
        forever begin
            @(negedge clk);
            if (nClear) begin
                m = '0;
                foreach (model_q[i]) m[model_q[i].a] = 1'b1;
                m[0] = 1'b0;
                chk("pend_mask", pend_mask, m);
                chk("mem_ready", mem_ready, model_q.size() < DEPTH);
                chk("alu_ready", alu_ready, model_alu_ready(model_q.size(), mem_valid));
                if (model_q.size() != 0 && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("load", load, 1'b1);
                    chk("Caddr", Caddr, e.a);
                    chk("C", C, e.d);
                end else begin
                    chk("load_idle", load, 1'b0);
                    chk("Caddr_idle", Caddr, 4'd0);
                    chk("C_idle", C, 16'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic mv, input logic [3:0] ma, input logic [15:0] md,
                          input logic av, input logic [3:0] aa, input logic [15:0] ad);
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [3:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 3));
    endfunction

    // Random sources that hold a request until it is accepted.
    task automatic rand_run(input int n, input int pm, input int pa);
        for (int i = 0; i < n; i++) begin
            if (!mem_valid || last_macc) begin
                mem_valid = ($urandom_range(0, 99) < pm);
                mem_addr  = rand_addr();
                mem_data  = 16'($urandom);
            end
            if (!alu_valid || last_aacc) begin
                alu_valid = ($urandom_range(0, 99) < pa);
                alu_addr  = rand_addr();
                alu_data  = 16'($urandom);
            end
            step();
        end
    endtask

    initial begin
        nClear = 1'b0;
        set_in(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        #12;
        chk("rst_load", load, 1'b0);
        chk("rst_Caddr", Caddr, 4'd0);
        chk("rst_C", C, 16'd0);
        chk("rst_pend", pend_mask, 16'd0);
        chk("rst_mem_ready", mem_ready, 1'b1);
        chk("rst_alu_ready", alu_ready, 1'b1);
        nClear = 1'b1;

        // Single ALU write.
        set_in(1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 16'hBEEF);
        step();
        set_in(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        chk("single_load", load, 1'b1);
        chk("single_Caddr", Caddr, 4'd5);
        chk("single_C", C, 16'hBEEF);
        chk("single_pend", pend_mask, 16'h0020);
        step();
        chk("single_after", load, 1'b0);

        // Dual accept to the same register: mem first, ALU second.
        set_in(1'b1, 4'd3, 16'h1111, 1'b1, 4'd3, 16'h2222);
        step();
        set_in(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        chk("dual_first", C, 16'h1111);
        step();
        chk("dual_second", C, 16'h2222);
        chk("dual_second_addr", Caddr, 4'd3);
        step();
        chk("dual_done", load, 1'b0);

        // Backpressure: both sources valid every cycle.
        set_in(1'b1, 4'd1, 16'hA001, 1'b1, 4'd2, 16'hA002);
        step();
        set_in(1'b1, 4'd4, 16'hA004, 1'b1, 4'd5, 16'hA005);
        step();
        chk("bp_mem_ready_c3", mem_ready, 1'b1);
        chk("bp_alu_ready_c3", alu_ready, 1'b0);
        rand_run(40, 100, 100);
        idle(6);

        // Zero register write is accepted but never written.
        set_in(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'd0);
        chk("zero_ready", mem_ready, 1'b1);
        step();
        set_in(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        chk("zero_load", load, 1'b0);
        chk("zero_pend", pend_mask, 16'd0);
        step();
        chk("zero_load2", load, 1'b0);

        // Coalesce candidate: head r2, tail r7=0001, then ALU r7=0009.
        set_in(1'b1, 4'd2, 16'h00AA, 1'b1, 4'd7, 16'h0001);
        step();
        set_in(1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 16'h0009);
        chk("coal_head", Caddr, 4'd2);
        step();
        set_in(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        chk("coal_r7_addr", Caddr, 4'd7);
        chk("coal_r7_data", C, COAL ? 16'h0009 : 16'h0001);
        idle(4);

        rand_run(1500, 60, 60);
        idle(6);

        // Mid-stream reset with three queued entries.
        set_in(1'b1, 4'd1, 16'hC001, 1'b1, 4'd2, 16'hC002);
        step();
        set_in(1'b1, 4'd3, 16'hC003, 1'b1, 4'd4, 16'hC004);
        step();
        set_in(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        chk("pre_rst_pend_nonzero", pend_mask != 16'd0, 1'b1);
        nClear = 1'b0;
        model_q.delete();
        exp_q.delete();
        #1;
        chk("mid_rst_load", load, 1'b0);
        chk("mid_rst_pend", pend_mask, 16'd0);
        #1;
        nClear = 1'b1;
        chk("post_rst_mem_ready", mem_ready, 1'b1);
        chk("post_rst_alu_ready", alu_ready, 1'b1);
        step();
        chk("post_rst_load", load, 1'b0);
        idle(3);

        rand_run(500, 40, 70);
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
